// File: rtl/apb_counter_regs.sv
// APB3 register front-end for the countdown counter: CTRL, LOAD, COUNT, STATUS; level irq = PEND & IRQ_EN.
// Transfer takes 2 + WAIT_STATES cycles; PREADY held low during wait states; register side effects visible the cycle after completion.
module apb_counter_regs #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              cnt_en,
   output logic [15:0]       cnt_load,
   output logic              cnt_load_strobe,
   input  logic [15:0]       cnt_count,
   input  logic              cnt_intr_req,
   output logic              irq
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t      state, phase, next_state;
   logic [3:0]  wait_cnt, wait_nxt;
   logic        irq_en, intr_q, pend;
   logic [1:0]  reg_sel;
   logic        addr_err, err, xfer_done, complete;
   logic        wr_ctrl, wr_load, w1c, intr_rise;
   logic [31:0] rdata;
   logic        unused_bits;

   assign reg_sel     = PADDR[3:2];
   assign addr_err    = |PADDR[ADDR_W-1:4];
   assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

   // The setup phase is decoded from IDLE in the cycle it appears, so the
   // access phase lands in ACCESS on the very next cycle (2-cycle transfer).
   always_comb begin
      phase      = state;
      next_state = state;
      wait_nxt   = wait_cnt;
      if (state == IDLE && PSEL && !PENABLE) phase = SETUP;
      case (phase)
         IDLE: next_state = IDLE;
         SETUP: begin
            next_state = ACCESS;
            wait_nxt   = WS;
         end
         ACCESS: begin
            if (!PSEL) begin
               next_state = IDLE;
               wait_nxt   = 4'd0;
            end else if (wait_cnt != 4'd0) begin
               wait_nxt = wait_cnt - 4'd1;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
            wait_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_nxt;
      end
   end

   assign err       = addr_err | (PWRITE & (reg_sel == REG_COUNT));
   assign xfer_done = (state == ACCESS) && PSEL && (wait_cnt == 4'd0);
   assign complete  = xfer_done && !err;
   assign wr_ctrl   = complete && PWRITE && (reg_sel == REG_CTRL);
   assign wr_load   = complete && PWRITE && (reg_sel == REG_LOAD);
   assign w1c       = complete && PWRITE && (reg_sel == REG_STATUS) && PWDATA[0];
   assign intr_rise = cnt_intr_req && !intr_q;

   always_comb begin
      rdata = 32'h0;
      case (reg_sel)
         REG_CTRL:   rdata = {30'h0, irq_en, cnt_en};
         REG_LOAD:   rdata = {16'h0, cnt_load};
         REG_COUNT:  rdata = {16'h0, cnt_count};
         REG_STATUS: rdata = {30'h0, cnt_intr_req, pend};
         default:    rdata = 32'h0;
      endcase
   end

   assign PREADY  = xfer_done;
   assign PSLVERR = xfer_done && err;
   assign PRDATA  = complete ? rdata : 32'h0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_en          <= 1'b0;
         irq_en          <= 1'b0;
         cnt_load        <= 16'h0;
         cnt_load_strobe <= 1'b0;
      end else begin
         cnt_load_strobe <= wr_load;
         if (wr_ctrl) begin
            cnt_en <= PWDATA[0];
            irq_en <= PWDATA[1];
         end
         if (wr_load) cnt_load <= PWDATA[15:0];
      end
   end

   // A new rising edge outranks a simultaneous W1C so no event is lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         intr_q <= 1'b0;
         pend   <= 1'b0;
         irq    <= 1'b0;
      end else begin
         intr_q <= cnt_intr_req;
         if (intr_rise)  pend <= 1'b1;
         else if (w1c)   pend <= 1'b0;
         irq <= pend & irq_en;
      end
   end

endmodule

// File: doc/apb_counter_regs.md
# apb_counter_regs

APB3 slave register front-end for the APB countdown counter. Decodes host reads and writes into control, load-value, count-readback and interrupt-status registers. Drives the counter's enable and load value, and consumes its count and interrupt request. Raises a single maskable, level interrupt to the system interrupt controller.

## Interface
Parameters:
- ADDR_W, default 12: PADDR width.
- WAIT_STATES, default 0: PREADY-low cycles inserted in each access phase (0..15).

Ports:
- clk  in  1: single clock; every register samples on the rising edge.
- reset  in  1: asynchronous, active-low reset.
- PSEL  in  1: APB select.
- PENABLE  in  1: APB access-phase flag.
- PWRITE  in  1: 1 = write, 0 = read.
- PADDR  in  ADDR_W: byte address.
- PWDATA  in  32: write data.
- PRDATA  out  32: read data.
- PREADY  out  1: transfer-complete flag.
- PSLVERR  out  1: error response, valid when PREADY = 1.
- cnt_en  out  1: counter enable; mirrors CTRL.EN.
- cnt_load  out  16: load value; mirrors LOAD.
- cnt_load_strobe  out  1: one-cycle pulse after each accepted LOAD write.
- cnt_count  in  16: live count from the counter.
- cnt_intr_req  in  1: counter terminal interrupt (level, same clock domain).
- irq  out  1: registered interrupt, equal to PEND & IRQ_EN.

## Operation
Register map. PADDR[3:2] selects the register. PADDR[1:0] is ignored.
- 0x0 CTRL (RW): bit0 EN, bit1 IRQ_EN. Other bits read 0. Reset value 0.
- 0x4 LOAD (RW): bits [15:0]. Upper bits read 0. Reset value 0.
- 0x8 COUNT (RO): {16'h0, cnt_count}, sampled in the completing cycle.
- 0xC STATUS: bit0 PEND (W1C), bit1 RAW (RO, = cnt_intr_req).

Error responses:
- PADDR[ADDR_W-1:4] != 0 gives PSLVERR = 1, PRDATA = 0, and no side effect.
- A write to COUNT gives PSLVERR = 1 and is otherwise ignored.
- A write to STATUS affects only PEND (W1C). RAW is read-only, and no error is raised.

Transfer FSM:
- IDLE → SETUP when PSEL = 1 and PENABLE = 0.
- SETUP → ACCESS unconditionally. The wait counter loads WAIT_STATES.
- ACCESS holds PREADY = 0 while the counter is nonzero, decrementing by 1 each cycle.
- ACCESS drives PREADY = 1 when the counter is 0. The transfer completes that cycle.
- After completion: → SETUP if PSEL = 1 and PENABLE = 0, otherwise → IDLE (back-to-back transfers are allowed).
- PSEL dropped during ACCESS: abort → IDLE with no side effect.
- PENABLE = 1 seen in IDLE (no setup phase): ignored, stay in IDLE.

Side effects occur only on the completing edge (ACCESS, PREADY = 1, PSLVERR = 0):
- A write to LOAD updates LOAD and asserts cnt_load_strobe for exactly the next cycle.
- A W1C to PEND (PWDATA bit0 = 1) clears PEND.

Interrupt:
- PEND sets on a rising edge of cnt_intr_req, detected against a registered copy.
- A set and a W1C clear in the same cycle: set wins, so PEND stays 1.
- irq is registered from PEND & IRQ_EN. Masking does not clear PEND.

## Timing
- Reset values: PRDATA 0, PREADY 0, PSLVERR 0, cnt_en 0, cnt_load 0, cnt_load_strobe 0, irq 0, FSM = IDLE, PEND 0, wait counter 0.
- Reset assertion mid-transfer returns every output and register to its reset value immediately. The interrupted transfer has no effect.
- PREADY, PSLVERR and PRDATA are nonzero only in ACCESS. They are 0 in IDLE and SETUP.
- PRDATA is combinational from the registers and is valid only while PREADY = 1.
- Transfer length: 2 + WAIT_STATES cycles, from the setup cycle to completion inclusive.
- cnt_en and cnt_load change 1 cycle after the completing edge. cnt_load_strobe rises in that same cycle.
- PEND sets on the edge that samples the cnt_intr_req 0→1 transition. irq follows 1 cycle later.
- A W1C clears irq 1 cycle after the completing edge, unless a new set arrives in the same cycle.

## Test plan
- Reset, then read all four registers with WAIT_STATES = 0:
  - CTRL, LOAD, COUNT (with cnt_count = 0) and STATUS all read 0.
  - PREADY = 1 on the second cycle of each transfer, PSLVERR = 0.
- Write LOAD = 0x0000_1234, then write CTRL = 0x3:
  - cnt_load = 0x1234, with cnt_load_strobe high for exactly 1 cycle.
  - cnt_en = 1.
  - Reading LOAD returns 0x1234.
- Drive cnt_intr_req 0→1 with IRQ_EN = 1:
  - PEND = 1 and irq = 1 one cycle later.
  - STATUS reads 0x3.
  - Writing STATUS = 0x1 clears irq, and STATUS then reads 0x2.
- Drive a cnt_intr_req rising edge in the same cycle as a W1C completes:
  - PEND remains 1 and irq remains 1.
- Set WAIT_STATES = 3 and read COUNT with cnt_count = 0x00AB:
  - PREADY is low for 3 ACCESS cycles.
  - PRDATA = 0x0000_00AB with PREADY = 1 on cycle 5.
- Access errors:
  - Write to 0x010: PSLVERR = 1 and no register changes.
  - Write to 0x8: PSLVERR = 1.
- Reset mid-transfer:
  - Assert reset during ACCESS of a LOAD write: LOAD stays 0 and no strobe is issued.
  - The FSM resumes in IDLE after reset release.
